// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcode width and constants, FSM state type.
// Imported by alu_core and seq_alu.
package seq_alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_NAND = 4'd5;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_OR   = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Opcodes handled by the single-cycle combinational core.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/seq_alu_core.sv
// alu_core: single-cycle combinational datapath for opcodes 0-7.
// Ports: op, a, b in; result, carryout, overflow out (zero 0 for other ops).
module alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   full;
    logic             c_msb_in;
    logic             ovf;

    // SLT reuses the subtractor.
    assign sub  = (op == OP_SUB) || (op == OP_SLT);
    assign b_x  = sub ? ~b : b;
    assign full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};

    // Carry into the MSB recovered from the MSB sum bit.
    assign c_msb_in = a[WIDTH-1] ^ b_x[WIDTH-1] ^ full[WIDTH-1];
    assign ovf      = c_msb_in ^ full[WIDTH];

    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result   = full[WIDTH-1:0];
                carryout = full[WIDTH];
                overflow = ovf;
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, full[WIDTH-1] ^ ovf};
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with registered result/flags and optional
// shift-and-add multiplier (macro SEQ_ALU_MUL_EN). Ports: clk, rst,
// in_valid/in_ready, op, a, b, out_valid/out_ready, result, flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic [WIDTH-1:0] core_res;
    logic             core_c;
    logic             core_o;

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     add_hi;
    logic [2*WIDTH-1:0] prod_nxt;

    // prod holds {partial sum, remaining multiplier bits}; one bit per cycle.
    assign add_hi   = prod_q[0]
                    ? {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q}
                    : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign prod_nxt = {add_hi, prod_q[WIDTH-1:1]};
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (core_res),
        .carryout (core_c),
        .overflow (core_o)
    );

    assign in_ready  = (state_q == S_IDLE) ||
                       ((state_q == S_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        ill_d       = ill_q;
`ifdef SEQ_ALU_MUL_EN
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
`endif
        if (state_q == S_BUSY) begin
`ifdef SEQ_ALU_MUL_EN
            prod_d = prod_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
                result_d    = prod_nxt[WIDTH-1:0];
                carry_d     = 1'b0;
                ovf_d       = |prod_nxt[2*WIDTH-1:WIDTH];
                zero_d      = (prod_nxt[WIDTH-1:0] == '0);
                ill_d       = 1'b0;
            end
`else
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
`endif
        end else begin
            // Consumer drained the held result.
            if ((state_q == S_HOLD) && out_ready) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (is_alu_op(op)) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    result_d    = core_res;
                    carry_d     = core_c;
                    ovf_d       = core_o;
                    zero_d      = (core_res == '0);
                    ill_d       = 1'b0;
                end
`ifdef SEQ_ALU_MUL_EN
                else if (op == OP_MUL) begin
                    state_d     = S_BUSY;
                    out_valid_d = 1'b0;
                    prod_d      = {{WIDTH{1'b0}}, b};
                    mcand_d     = a;
                    cnt_d       = '0;
                end
`endif
                else begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = 1'b1;
                    ill_d       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            ill_q       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            ill_q       <= ill_d;
`ifdef SEQ_ALU_MUL_EN
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed stimulus with a scoreboard queue and a monitor that
// checks every out_valid/out_ready transfer of seq_alu (WIDTH=32).
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carryout;
    logic          overflow;
    logic          zero;
    logic          illegal;

    typedef struct {
        string        nm;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         i;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   n_out;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [W-1:0] r,
                                input logic c, input logic o,
                                input logic z, input logic i);
        exp_t e;
        e.nm = nm;
        e.r  = r;
        e.c  = c;
        e.o  = o;
        e.z  = z;
        e.i  = i;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] o_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input exp_t e,
                        output int waits);
        in_valid = 1'b1;
        op       = o_i;
        a        = a_i;
        b        = b_i;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: accept timeout got 0 expected 1", e.nm);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: one transfer per negedge with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none",
                         result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, {28'd0, result, carryout, overflow, zero, illegal},
                    {28'd0, e.r, e.c, e.o, e.z, e.i});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int bad;
        int base;
        n_chk     = 0;
        n_fail    = 0;
        n_out     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_regs", {28'd0, result, carryout, overflow, zero, illegal},
            64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(OP_ADD, 32'h7FFF_FFFF, 32'h1,
             mk("add_ovf", 32'h8000_0000, 0, 1, 0, 0), w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_latency", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        send(OP_SUB, 32'd5, 32'd5, mk("sub_zero", 32'd0, 1, 0, 1, 0), w);
        send(OP_SLT, 32'h8000_0000, 32'd1,
             mk("slt_ovf", 32'd1, 0, 0, 0, 0), w);
        send(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F,
             mk("xor", 32'hF00F_F00F, 0, 0, 0, 0), w);
        send(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F,
             mk("and", 32'h0F00_0F00, 0, 0, 0, 0), w);
        send(OP_NAND, 32'hFF00_FF00, 32'h0F0F_0F0F,
             mk("nand", 32'hF0FF_F0FF, 0, 0, 0, 0), w);
        send(OP_NOR, 32'hFF00_FF00, 32'h0F0F_0F0F,
             mk("nor", 32'h00F0_00F0, 0, 0, 0, 0), w);
        send(OP_OR, 32'hFF00_FF00, 32'h0F0F_0F0F,
             mk("or", 32'hFF0F_FF0F, 0, 0, 0, 0), w);
        send(OP_SUB, 32'd3, 32'd5,
             mk("sub_neg", 32'hFFFF_FFFE, 0, 0, 0, 0), w);
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1,
             mk("add_carry", 32'd0, 1, 0, 1, 0), w);
        send(4'd12, 32'hFFFF_FFFF, 32'd0,
             mk("op12_illegal", 32'd0, 0, 0, 1, 1), w);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;

`ifdef SEQ_ALU_MUL_EN
        send(OP_MUL, 32'h1_0000, 32'h1_0000,
             mk("mul_big", 32'd0, 0, 1, 1, 0), w);
        in_valid = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("mul_busy_ready", 64'(in_ready), 64'd0);
            if (out_valid) break;
        end
        chk("mul_latency", 64'(n), 64'(W + 1));
        @(posedge clk);
        #1;
        send(OP_MUL, 32'd7, 32'd6, mk("mul_small", 32'd42, 0, 0, 0, 0), w);
        in_valid = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk("mul_small_latency", 64'(n), 64'(W + 1));
`else
        send(OP_MUL, 32'd7, 32'd6, mk("op8_illegal", 32'd0, 0, 0, 1, 1), w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("op8_latency", 64'(out_valid), 64'd1);
`endif
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2, mk("bp_add", 32'd3, 0, 0, 0, 0), w);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd3);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base = n_out;
        send(OP_ADD, 32'd10, 32'd20, mk("b2b_add", 32'd30, 0, 0, 0, 0), w);
        chk("b2b_wait0", 64'(w), 64'd0);
        send(OP_SUB, 32'd0, 32'd1,
             mk("b2b_sub", 32'hFFFF_FFFF, 0, 0, 0, 0), w);
        chk("b2b_wait1", 64'(w), 64'd0);
        send(OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555,
             mk("b2b_xor", 32'd0, 0, 0, 1, 0), w);
        chk("b2b_wait2", 64'(w), 64'd0);
        send(OP_OR, 32'd0, 32'h8000_0000,
             mk("b2b_or", 32'h8000_0000, 0, 0, 0, 0), w);
        chk("b2b_wait3", 64'(w), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b_count", 64'(n_out - base), 64'd5);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(OP_MUL, 32'd3, 32'd3, mk("abort", 32'd0, 0, 0, 0, 0), w);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("abort_no_valid", 64'(bad), 64'd0);
        @(posedge clk);
        #1;

        send(OP_ADD, 32'd0, 32'd0, mk("post_rst_add", 32'd0, 0, 0, 1, 0), w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
